// File: rtl/ehgu_stream_packer.sv
// ehgu_stream_packer: packs RATIO narrow FIFO beats into one wide word
// with a per-lane keep mask; flush closes a partial word early.
module ehgu_stream_packer #(
    parameter int IN_W      = 8,
    parameter int RATIO     = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    input  logic [IN_W-1:0]       in_data,
    output logic                  in_ready,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IN_W*RATIO-1:0] out_data,
    output logic [RATIO-1:0]      out_keep,
    output logic [15:0]           word_cnt
);

    localparam int OW = IN_W * RATIO;
    localparam int PW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [PW-1:0] LAST = PW'(RATIO - 1);

    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_n;
    logic [PW-1:0]    eff_ptr;
    logic [OW-1:0]    acc;
    logic [OW-1:0]    acc_n;
    logic [OW-1:0]    acc_w;
    logic [RATIO-1:0] acc_keep;
    logic [RATIO-1:0] keep_n;
    logic [RATIO-1:0] keep_w;
    logic             flush_pend;
    logic             pend_n;
    logic             out_free;
    logic             beat;
    logic             move_pend;
    logic             close;
    logic             load;
    logic [OW-1:0]    load_data;
    logic [RATIO-1:0] load_keep;
    int               lane;

    assign out_free = ~out_valid | out_ready;

    // Stall when the closing beat or a pending flush has nowhere to go.
    assign in_ready = rstn
                    & ~((ptr == LAST) & out_valid & ~out_ready)
                    & ~(flush_pend & ~out_free);

    always_comb begin
        beat      = in_valid & in_ready;
        move_pend = flush_pend & out_free;
        eff_ptr   = move_pend ? '0 : ptr;
        acc_w     = move_pend ? '0 : acc;
        keep_w    = move_pend ? '0 : acc_keep;
        lane      = (LSB_FIRST != 0) ? int'(eff_ptr)
                                     : RATIO - 1 - int'(eff_ptr);
        if (beat) begin
            for (int k = 0; k < RATIO; k++) begin
                if (k == lane) begin
                    acc_w[k*IN_W +: IN_W] = in_data;
                    keep_w[k]             = 1'b1;
                end
            end
        end
        close     = beat & (eff_ptr == LAST);
        load      = 1'b0;
        load_data = acc_w;
        load_keep = keep_w;
        ptr_n     = ptr;
        acc_n     = acc_w;
        keep_n    = keep_w;
        if (close) begin
            load   = 1'b1;
            acc_n  = '0;
            keep_n = '0;
            ptr_n  = '0;
        end else if (move_pend) begin
            // Pending partial word leaves; a beat taken now starts a new word.
            load      = 1'b1;
            load_data = acc;
            load_keep = acc_keep;
            ptr_n     = beat ? PW'(1) : '0;
        end else if (beat) begin
            ptr_n = ptr + PW'(1);
        end
        pend_n = (flush_pend & ~move_pend) | (flush & (ptr_n != '0));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr        <= '0;
            acc        <= '0;
            acc_keep   <= '0;
            flush_pend <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_keep   <= '0;
            word_cnt   <= '0;
        end else begin
            ptr        <= ptr_n;
            acc        <= acc_n;
            acc_keep   <= keep_n;
            flush_pend <= pend_n;
            out_valid  <= load | (out_valid & ~out_ready);
            if (load) begin
                out_data <= load_data;
                out_keep <= load_keep;
            end
            if (out_valid && out_ready)
                word_cnt <= word_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_ehgu_stream_packer.sv
// tb_ehgu_stream_packer: directed stimulus with a queue scoreboard
// for an LSB-first and an MSB-first packer instance.
module tb_ehgu_stream_packer;

    logic        clk;
    logic        rstn;
    logic        iv1, ir1, fl1, ov1, or1;
    logic [7:0]  id1;
    logic [31:0] od1;
    logic [3:0]  ok1;
    logic [15:0] wc1;
    logic        iv2, ir2, fl2, ov2, or2;
    logic [7:0]  id2;
    logic [31:0] od2;
    logic [3:0]  ok2;
    logic [15:0] wc2;

    int tests = 0;
    int fails = 0;
    logic [35:0] q1[$];
    logic [35:0] q2[$];

    ehgu_stream_packer #(.IN_W(8), .RATIO(4), .LSB_FIRST(1)) dut1 (
        .clk(clk), .rstn(rstn),
        .in_valid(iv1), .in_data(id1), .in_ready(ir1), .flush(fl1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1),
        .out_keep(ok1), .word_cnt(wc1)
    );

    ehgu_stream_packer #(.IN_W(8), .RATIO(4), .LSB_FIRST(0)) dut2 (
        .clk(clk), .rstn(rstn),
        .in_valid(iv2), .in_data(id2), .in_ready(ir2), .flush(fl2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2),
        .out_keep(ok2), .word_cnt(wc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rstn && ov1 && or1) begin
            if (q1.size() == 0) begin
                tests = tests + 1;
                fails = fails + 1;
                $display("FAIL mon1_unexpected actual=%h/%h required=none",
                         od1, ok1);
            end else begin
                chk("mon1_word", {od1, ok1}, q1.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rstn && ov2 && or2) begin
            if (q2.size() == 0) begin
                tests = tests + 1;
                fails = fails + 1;
                $display("FAIL mon2_unexpected actual=%h/%h required=none",
                         od2, ok2);
            end else begin
                chk("mon2_word", {od2, ok2}, q2.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one beat; returns #1 after the edge that accepted it.
    task automatic beat(input bit sel, input logic [7:0] d, input bit f);
        int n;
        n = 0;
        if (sel) begin iv2 = 1'b1; id2 = d; fl2 = f; end
        else     begin iv1 = 1'b1; id1 = d; fl1 = f; end
        forever begin
            @(negedge clk);
            if ((sel ? ir2 : ir1) == 1'b1) break;
            n++;
            if (n > 50) begin
                tests = tests + 1;
                fails = fails + 1;
                $display("FAIL beat_timeout actual=stalled required=accept");
                break;
            end
        end
        @(posedge clk);
        #1;
        iv1 = 1'b0; fl1 = 1'b0;
        iv2 = 1'b0; fl2 = 1'b0;
    endtask

    task automatic do_flush();
        fl1 = 1'b1;
        @(posedge clk);
        #1;
        fl1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        iv1 = 0; id1 = 0; fl1 = 0; or1 = 0;
        iv2 = 0; id2 = 0; fl2 = 0; or2 = 0;
        cyc(3);
        chk("rst_valid", ov1, 1'b0);
        chk("rst_data", od1, 32'h0);
        chk("rst_keep", ok1, 4'h0);
        chk("rst_cnt", wc1, 16'h0);
        chk("rst_ready", ir1, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        cyc(1);

        // 1: streaming
        or1 = 1'b1;
        q1.push_back({32'h09060300, 4'hF});
        q1.push_back({32'h15120F0C, 4'hF});
        for (int i = 0; i < 8; i++) begin
            beat(0, 8'(i * 3), 0);
            if (i == 3) chk("t1_latency", ov1, 1'b1);
        end
        cyc(4);
        chk("t1_cnt", wc1, 16'd2);

        // 2: backpressure
        or1 = 1'b0;
        q1.push_back({32'h24232221, 4'hF});
        q1.push_back({32'h34333231, 4'hF});
        for (int i = 0; i < 4; i++) beat(0, 8'(8'h21 + i), 0);
        for (int i = 0; i < 3; i++) beat(0, 8'(8'h31 + i), 0);
        iv1 = 1'b1;
        id1 = 8'h34;
        repeat (2) begin
            @(negedge clk);
            chk("t2_stall", ir1, 1'b0);
        end
        @(posedge clk);
        #1;
        or1 = 1'b1;
        @(negedge clk);
        chk("t2_release", ir1, 1'b1);
        @(posedge clk);
        #1;
        or1 = 1'b0;
        iv1 = 1'b0;
        chk("t2_next_valid", ov1, 1'b1);
        chk("t2_next_data", od1, 32'h34333231);
        chk("t2_next_keep", ok1, 4'hF);
        cyc(2);
        or1 = 1'b1;
        cyc(3);
        chk("t2_cnt", wc1, 16'd4);

        // 3: flush of a partial word, then flush when idle
        q1.push_back({32'h0000BBAA, 4'h3});
        beat(0, 8'hAA, 0);
        beat(0, 8'hBB, 0);
        do_flush();
        cyc(4);
        chk("t3_cnt", wc1, 16'd5);
        do_flush();
        cyc(5);
        chk("t3_idle_valid", ov1, 1'b0);
        chk("t3_idle_cnt", wc1, 16'd5);

        // 4: flush together with a beat
        q1.push_back({32'h00332211, 4'h7});
        beat(0, 8'h11, 0);
        beat(0, 8'h22, 0);
        beat(0, 8'h33, 1);
        cyc(4);
        q1.push_back({32'h44434241, 4'hF});
        beat(0, 8'h41, 0);
        beat(0, 8'h42, 0);
        beat(0, 8'h43, 0);
        beat(0, 8'h44, 1);
        cyc(5);
        chk("t4_cnt", wc1, 16'd7);
        chk("t4_idle_valid", ov1, 1'b0);

        // 5: MSB-first lane order
        or2 = 1'b1;
        q2.push_back({32'h01020304, 4'hF});
        q2.push_back({32'h05060000, 4'hC});
        for (int i = 1; i <= 4; i++) beat(1, 8'(i), 0);
        beat(1, 8'h05, 0);
        beat(1, 8'h06, 1);
        cyc(4);
        chk("t5_cnt", wc2, 16'd2);

        // 6: reset mid-word with a held output word
        or1 = 1'b0;
        for (int i = 0; i < 4; i++) beat(0, 8'(8'h61 + i), 0);
        beat(0, 8'h51, 0);
        beat(0, 8'h52, 0);
        rstn = 1'b0;
        #1;
        chk("t6_valid", ov1, 1'b0);
        chk("t6_data", od1, 32'h0);
        chk("t6_keep", ok1, 4'h0);
        chk("t6_cnt", wc1, 16'h0);
        chk("t6_ready", ir1, 1'b0);
        cyc(2);
        @(negedge clk);
        rstn = 1'b1;
        cyc(1);
        chk("t6_post_valid", ov1, 1'b0);
        or1 = 1'b1;
        q1.push_back({32'h08070605, 4'hF});
        for (int i = 5; i <= 8; i++) beat(0, 8'(i), 0);
        cyc(4);
        chk("t6_cnt", wc1, 16'd1);

        cyc(3);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        chk("q2_drained", 64'(q2.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
